reaction_delay_timer: RTL and testbench
=======================================

Name: reaction_delay_timer

Overview:
Consumer side of the pseudo-random number generator. It requests a fresh value by pulsing the generator's enable input, then derives a random stimulus delay from that value. It counts the delay down in milliseconds, lights the stimulus LED and measures the player's reaction time in milliseconds. It sits between the button/start inputs and the score display logic of the reaction timer.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency; TICK_CYCLES = CLK_FREQ_HZ/1000 (integer, >= 2)
MIN_DELAY_MS, 1000, fixed part of the stimulus delay
DELAY_MASK_BITS, 12, low bits of the random value added to MIN_DELAY_MS (range 0..2^N-1 ms)
TIMEOUT_MS, 9999, reaction window; must fit in 14 bits

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs
start  input  1  synchronous, debounced level; a rising edge starts a round
button  input  1  synchronous, debounced reaction button level (1 = pressed)
pseudoRandomNumber  input  16  value from the generator, stable 2 cycles after rngEnable rises
rngEnable  output  1  one-cycle pulse that advances the generator
ledOn  output  1  stimulus LED
reactionTimeMs  output  14  measured reaction time; held in RESULT
resultValid  output  1  high in RESULT for a valid measurement
falseStart  output  1  high in RESULT if the button was pressed before the stimulus
timedOut  output  1  high in RESULT if no press occurred within TIMEOUT_MS
busy  output  1  high in every state except IDLE and RESULT

Behaviour:
- Reset: state IDLE; all outputs 0; counters, prescaler and start edge register cleared.
- Start edge: startPrev is registered each cycle; startEdge = start & ~startPrev.
- ms tick: prescaler counts 0..TICK_CYCLES-1 and pulses tick on its terminal count. It clears on entry to WAIT_DELAY and STIMULUS, so the first ms is full length.
- IDLE: on startEdge go to REQ_RNG.
- REQ_RNG (1 cycle): rngEnable=1, then go to SETTLE.
- SETTLE (1 cycle): rngEnable=0, then go to LOAD.
- LOAD (1 cycle): delayMs = MIN_DELAY_MS + (pseudoRandomNumber & (2^DELAY_MASK_BITS-1)), zero-extended to 17 bits with no overflow. Clear reactionTimeMs and all flags. Go to WAIT_DELAY.
- WAIT_DELAY: decrement delayMs on each tick.
  - button=1 in any cycle: go to RESULT with falseStart=1, reactionTimeMs=0.
  - Tick with delayMs==1 (and no button): go to STIMULUS.
  - The button check has priority over the tick.
- STIMULUS: ledOn=1; reactionTimeMs increments on each tick.
  - button=1: go to RESULT with resultValid=1, holding the current count. A press on the entry cycle gives 0.
  - Tick that makes the count equal TIMEOUT_MS (and no button): go to RESULT with timedOut=1, reactionTimeMs=TIMEOUT_MS.
  - The button check has priority over the tick.
- RESULT: ledOn=0; busy=0; flags and reactionTimeMs are held. Exactly one flag is set. On startEdge go to REQ_RNG; this clears the flags in LOAD.
- startEdge in REQ_RNG, SETTLE, LOAD, WAIT_DELAY or STIMULUS is ignored.
- Timing: ledOn rises delayMs*TICK_CYCLES cycles after the first WAIT_DELAY cycle. Start edge to first WAIT_DELAY cycle is 4 cycles (IDLE detect, REQ_RNG, SETTLE, LOAD).
- Mid-operation reset: asynchronous return to IDLE with all outputs low. rngEnable must not glitch high.
- All outputs are registered.

Decomposition:
- Shared package reaction_timer_pkg holds:
  - the state enum (IDLE, REQ_RNG, SETTLE, LOAD, WAIT_DELAY, STIMULUS, RESULT);
  - REACTION_W=14;
  - the TIMEOUT_MS/MIN_DELAY_MS defaults.
- One natural sub-module, ms_tick_gen: a prescaler with a synchronous clear and a tick output, parameterised by TICK_CYCLES, reusable by the display blink logic.

Test Plan:
All scenarios use CLK_FREQ_HZ=10000 (10 cycles/ms), MIN_DELAY_MS=2, DELAY_MASK_BITS=3, TIMEOUT_MS=20.
- Reset mid-STIMULUS: assert reset -> ledOn, busy, rngEnable and all flags go to 0 immediately, state is IDLE, and the next start edge works normally.
- Normal round: start edge, pseudoRandomNumber=0x00AD -> one rngEnable pulse at cycle 1; delay=2+5=7 ms; ledOn rises 70 cycles after WAIT_DELAY entry; press button 35 cycles later -> reactionTimeMs=3, resultValid=1, busy=0.
- False start: pseudoRandomNumber=0xFFFF (delay 9 ms); press at 40 cycles into WAIT_DELAY -> falseStart=1, reactionTimeMs=0, ledOn never rises.
- Timeout: pseudoRandomNumber=0x0000 (delay 2 ms); no press -> after 200 cycles of ledOn, timedOut=1, reactionTimeMs=20, ledOn=0.
- Ignored and repeated start: start edges during WAIT_DELAY/STIMULUS -> no extra rngEnable pulses; a start edge in RESULT -> a new round with flags cleared in LOAD, and the second pseudoRandomNumber value used.

Source files
------------

// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction timer: FSM state encoding,
// result width, delay arithmetic and default timing values.
package reaction_timer_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQ_RNG    = 3'd1,
    SETTLE     = 3'd2,
    LOAD       = 3'd3,
    WAIT_DELAY = 3'd4,
    STIMULUS   = 3'd5,
    RESULT     = 3'd6
  } state_t;

  localparam int REACTION_W           = 14;
  localparam int DELAY_W              = 17;
  localparam int RND_W                = 16;
  localparam int DEFAULT_TIMEOUT_MS   = 9999;
  localparam int DEFAULT_MIN_DELAY_MS = 1000;

  // Stimulus delay in ms: fixed minimum plus the masked random value.
  // Both operands fit in 16 bits, so the 17-bit sum cannot overflow.
  function automatic logic [DELAY_W-1:0] stimulus_delay(
    input logic [DELAY_W-1:0] min_ms,
    input logic [RND_W-1:0]   rnd,
    input logic [RND_W-1:0]   mask
  );
    return min_ms + {1'b0, rnd & mask};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_CYCLES-1 and flags the terminal
// count. A synchronous clear restarts the count so the next period is full.
module ms_tick_gen #(
  parameter int TICK_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int              CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority, then wrap on terminal count, else count up.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Prescaler counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tick comes straight from the counter register; it must not depend on
  // clr_i because the consumer derives clr_i from its own use of the tick.
  assign tick_o = (cnt_q == TERM);

endmodule

// File: rtl/reaction_delay_timer.sv
// Reaction delay timer: pulses the random generator, waits a random delay,
// lights the stimulus LED and measures the player's reaction time in ms.
module reaction_delay_timer
  import reaction_timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 50000000,
  parameter int MIN_DELAY_MS    = DEFAULT_MIN_DELAY_MS,
  parameter int DELAY_MASK_BITS = 12,
  parameter int TIMEOUT_MS      = DEFAULT_TIMEOUT_MS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  button,
  input  logic [15:0]           pseudoRandomNumber,
  output logic                  rngEnable,
  output logic                  ledOn,
  output logic [REACTION_W-1:0] reactionTimeMs,
  output logic                  resultValid,
  output logic                  falseStart,
  output logic                  timedOut,
  output logic                  busy
);

  localparam int                    TICK_CYCLES = CLK_FREQ_HZ / 1000;
  localparam logic [RND_W-1:0]      DELAY_MASK  = RND_W'((32'd1 << DELAY_MASK_BITS) - 32'd1);
  localparam logic [DELAY_W-1:0]    MIN_DELAY   = DELAY_W'(MIN_DELAY_MS);
  localparam logic [REACTION_W-1:0] TIMEOUT_VAL = REACTION_W'(TIMEOUT_MS);

  state_t                  state_q, state_d;
  logic                    start_prev_q;
  logic                    start_edge;
  logic [DELAY_W-1:0]      delay_q, delay_d;
  logic [REACTION_W-1:0]   reaction_q, reaction_d;
  logic [REACTION_W-1:0]   reaction_inc;
  logic                    false_start_q, false_start_d;
  logic                    result_valid_q, result_valid_d;
  logic                    timed_out_q, timed_out_d;
  logic                    rng_enable_q, led_on_q, busy_q;
  logic                    tick;
  logic                    tick_clr;

  assign start_edge   = start & ~start_prev_q;
  assign reaction_inc = reaction_q + REACTION_W'(1);
  // Restart the prescaler on every state change so WAIT_DELAY and STIMULUS
  // both begin with a full-length first millisecond.
  assign tick_clr     = (state_d != state_q);

  ms_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_ms_tick (
    .clk    (clk),
    .rst    (reset),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Next-state, delay countdown, reaction counter and result flags.
  always_comb begin
    state_d        = state_q;
    delay_d        = delay_q;
    reaction_d     = reaction_q;
    false_start_d  = false_start_q;
    result_valid_d = result_valid_q;
    timed_out_d    = timed_out_q;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = REQ_RNG;
        end else begin
          state_d = IDLE;
        end
      end
      REQ_RNG: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        state_d = LOAD;
      end
      LOAD: begin
        delay_d        = stimulus_delay(MIN_DELAY, pseudoRandomNumber, DELAY_MASK);
        reaction_d     = '0;
        false_start_d  = 1'b0;
        result_valid_d = 1'b0;
        timed_out_d    = 1'b0;
        state_d        = WAIT_DELAY;
      end
      WAIT_DELAY: begin
        // Button before the stimulus wins over a coincident tick.
        if (button) begin
          state_d       = RESULT;
          false_start_d = 1'b1;
          reaction_d    = '0;
        end else if (tick) begin
          if (delay_q <= DELAY_W'(1)) begin
            state_d = STIMULUS;
          end else begin
            delay_d = delay_q - DELAY_W'(1);
          end
        end else begin
          state_d = WAIT_DELAY;
        end
      end
      STIMULUS: begin
        // A press on the same cycle as the timeout tick still counts as valid.
        if (button) begin
          state_d        = RESULT;
          result_valid_d = 1'b1;
        end else if (tick) begin
          if (reaction_inc >= TIMEOUT_VAL) begin
            state_d     = RESULT;
            timed_out_d = 1'b1;
            reaction_d  = TIMEOUT_VAL;
          end else begin
            reaction_d = reaction_inc;
          end
        end else begin
          state_d = STIMULUS;
        end
      end
      RESULT: begin
        if (start_edge) begin
          state_d = REQ_RNG;
        end else begin
          state_d = RESULT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; decoded outputs follow state_d so
  // they change on the same edge as the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      start_prev_q   <= 1'b0;
      delay_q        <= '0;
      reaction_q     <= '0;
      false_start_q  <= 1'b0;
      result_valid_q <= 1'b0;
      timed_out_q    <= 1'b0;
      rng_enable_q   <= 1'b0;
      led_on_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_prev_q   <= start;
      delay_q        <= delay_d;
      reaction_q     <= reaction_d;
      false_start_q  <= false_start_d;
      result_valid_q <= result_valid_d;
      timed_out_q    <= timed_out_d;
      rng_enable_q   <= (state_d == REQ_RNG);
      led_on_q       <= (state_d == STIMULUS);
      busy_q         <= (state_d != IDLE) && (state_d != RESULT);
    end
  end

  assign rngEnable      = rng_enable_q;
  assign ledOn          = led_on_q;
  assign reactionTimeMs = reaction_q;
  assign resultValid    = result_valid_q;
  assign falseStart     = false_start_q;
  assign timedOut       = timed_out_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_reaction_delay_timer.sv
// Self-checking bench for reaction_delay_timer: table of rounds with
// hand-computed results, randomized rounds checked against a ms-level model,
// and a hand-written mid-stimulus reset sequence.
module tb_reaction_delay_timer;

  localparam int TICK      = 10;
  localparam int MIN_D     = 2;
  localparam int MASK_BITS = 3;
  localparam int TO_MS     = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        button;
  logic [15:0] prn;
  logic        rng_en, led_on, result_valid, false_start, timed_out, busy;
  logic [13:0] reaction_ms;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reaction_delay_timer #(
    .CLK_FREQ_HZ     (10000),
    .MIN_DELAY_MS    (MIN_D),
    .DELAY_MASK_BITS (MASK_BITS),
    .TIMEOUT_MS      (TO_MS)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .button             (button),
    .pseudoRandomNumber (prn),
    .rngEnable          (rng_en),
    .ledOn              (led_on),
    .reactionTimeMs     (reaction_ms),
    .resultValid        (result_valid),
    .falseStart         (false_start),
    .timedOut           (timed_out),
    .busy               (busy)
  );

  typedef struct {
    logic [15:0] prn;
    int          press;   // WAIT_DELAY-relative cycle of the press, -1 = none
    bit          toggle;  // wiggle start during the round
    bit          fs;
    bit          valid;
    bit          to;
    int          rt;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int delay_cycles(input logic [15:0] p);
    return (MIN_D + (int'(p) % (1 << MASK_BITS))) * TICK;
  endfunction

  // Reference: reaction outcome from the delay in ms and the press time.
  function automatic vec_t model(input logic [15:0] p, input int press);
    vec_t v;
    int   d;
    d = delay_cycles(p);
    v.prn = p; v.press = press; v.toggle = 1'b0;
    v.fs = 1'b0; v.valid = 1'b0; v.to = 1'b0; v.rt = 0;
    if (press >= 0 && press < d) begin
      v.fs = 1'b1;
    end else if (press >= 0 && (press - d) < TO_MS * TICK) begin
      v.valid = 1'b1;
      v.rt    = (press - d) / TICK;
    end else begin
      v.to = 1'b1;
      v.rt = TO_MS;
    end
    return v;
  endfunction

  task automatic run_round(input vec_t v);
    int d, exp_end, rise, pulses, end_idx;
    d       = delay_cycles(v.prn);
    exp_end = (v.press >= 0 && v.press < d + TO_MS * TICK) ? v.press + 1 : d + TO_MS * TICK;
    rise    = -1;
    end_idx = -1;
    start   = 1'b0;
    button  = 1'b0;
    prn     = v.prn;
    step();
    start = 1'b1;
    step();
    check("rng_pulse_cycle1", int'(rng_en), 1);
    check("busy_in_req", int'(busy), 1);
    pulses = int'(rng_en);
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(rng_en);
    end
    check("flags_cleared_in_load", int'({result_valid, false_start, timed_out}), 0);
    check("reaction_cleared_in_load", int'(reaction_ms), 0);
    for (int w = 0; w < d + TO_MS * TICK + 20; w++) begin
      if (w > 0) pulses += int'(rng_en);
      if (led_on && rise < 0) rise = w;
      if (result_valid || false_start || timed_out) begin
        end_idx = w;
        break;
      end
      if (v.toggle) start = w[2];
      if (w == v.press) button = 1'b1;
      step();
    end
    start  = 1'b0;
    button = 1'b0;
    check("led_rise_cycle", rise, v.fs ? -1 : d);
    check("result_cycle", end_idx, exp_end);
    check("rng_pulses", pulses, 1);
    check("false_start", int'(false_start), int'(v.fs));
    check("result_valid", int'(result_valid), int'(v.valid));
    check("timed_out", int'(timed_out), int'(v.to));
    check("reaction_ms", int'(reaction_ms), v.rt);
    check("led_off_in_result", int'(led_on), 0);
    check("busy_in_result", int'(busy), 0);
    repeat (3) step();
    check("reaction_held", int'(reaction_ms), v.rt);
    check("flags_held", int'({false_start, result_valid, timed_out}),
          int'({v.fs, v.valid, v.to}));
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{16'h00AD, 105, 1'b0, 1'b0, 1'b1, 1'b0, 3};   // normal, delay 7 ms
    tbl[1] = '{16'hFFFF,  40, 1'b0, 1'b1, 1'b0, 1'b0, 0};   // false start, delay 9 ms
    tbl[2] = '{16'h0000,  -1, 1'b0, 1'b0, 1'b0, 1'b1, 20};  // timeout, delay 2 ms
    tbl[3] = '{16'h0003,  50, 1'b0, 1'b0, 1'b1, 1'b0, 0};   // press on stimulus entry
    tbl[4] = '{16'h0001,  29, 1'b0, 1'b1, 1'b0, 1'b0, 0};   // press on final delay tick
    tbl[5] = '{16'h0002, 239, 1'b0, 1'b0, 1'b1, 1'b0, 19};  // press on timeout tick
    tbl[6] = '{16'h0004, 137, 1'b1, 1'b0, 1'b1, 1'b0, 7};   // start edges ignored mid-round

    reset  = 1'b1;
    start  = 1'b0;
    button = 1'b0;
    prn    = 16'h0000;
    repeat (3) step();
    check("reset_outputs",
          int'({rng_en, led_on, result_valid, false_start, timed_out, busy}), 0);
    check("reset_reaction", int'(reaction_ms), 0);
    reset = 1'b0;
    step();

    // Reset in the middle of the stimulus phase.
    start = 1'b1;
    step();
    repeat (3 + 2 * TICK + 5) step();
    check("led_on_before_reset", int'(led_on), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs",
          int'({rng_en, led_on, result_valid, false_start, timed_out, busy}), 0);
    check("async_reset_reaction", int'(reaction_ms), 0);
    step();
    check("rng_low_in_reset", int'(rng_en), 0);
    reset = 1'b0;
    start = 1'b0;
    step();
    check("idle_after_reset", int'(busy), 0);

    // Table rounds; each later round starts from RESULT of the previous one.
    for (int i = 0; i < 7; i++) begin
      run_round(tbl[i]);
    end

    // Randomized rounds against the model.
    for (int r = 0; r < 20; r++) begin
      logic [15:0] p;
      int          press;
      vec_t        v;
      p     = 16'($urandom);
      press = ($urandom_range(0, 7) == 0) ? -1
            : int'($urandom_range(0, delay_cycles(p) + TO_MS * TICK + 15));
      v        = model(p, press);
      v.toggle = 1'($urandom_range(0, 1));
      run_round(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
